// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 BCM scan controller.
package hub75_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrime,
    StShift,
    StLatch,
    StDisplay
  } state_e;

  // Channel positions inside one rd_data word, R1 in the most significant slot.
  localparam int unsigned ChR1 = 5;
  localparam int unsigned ChG1 = 4;
  localparam int unsigned ChB1 = 3;
  localparam int unsigned ChR2 = 2;
  localparam int unsigned ChG2 = 1;
  localparam int unsigned ChB2 = 0;
  localparam int unsigned NumChannels = 6;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Binary-weighted on-time counter: loads ON_BASE<<plane and holds OE_N low that many cycles.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = 4,
  parameter int unsigned ON_BASE   = 8,
  parameter int unsigned PlaneW    = 2
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [PlaneW-1:0] plane_i,
  output logic              expire_o,
  output logic              oe_n_o
);

  localparam int unsigned CntW = clog2((ON_BASE << (BIT_DEPTH - 1)) + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            oe_n_q, oe_n_d;

  always_comb begin
    cnt_d  = cnt_q;
    oe_n_d = oe_n_q;
    if (load_i) begin
      cnt_d  = CntW'(ON_BASE) << plane_i;
      oe_n_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - CntW'(1);
      // Blank on the same edge the FSM leaves DISPLAY.
      oe_n_d = (cnt_q == CntW'(1));
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      oe_n_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      oe_n_q <= oe_n_d;
    end
  end

  assign expire_o = (cnt_q == CntW'(1));
  assign oe_n_o   = oe_n_q;

endmodule

// File: rtl/hub75_bcm_scanner.sv
// HUB75 scan controller: streams one bit-plane per row pair from the frame buffer, latches it,
// and lights it for a significance-weighted time.
module hub75_bcm_scanner
  import hub75_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH = 32,
  parameter int unsigned SCREEN_DEPTH = 16,
  parameter int unsigned BIT_DEPTH    = 4,
  parameter int unsigned ON_BASE      = 8
) (
  input  logic                              clk_in,
  input  logic                              rst_n,
  input  logic                              enable,
  output logic                              rd_en,
  output logic [clog2(SCREEN_DEPTH)-1:0]    rd_row,
  output logic [clog2(SCREEN_WIDTH)-1:0]    rd_col,
  input  logic [NumChannels*BIT_DEPTH-1:0]  rd_data,
  output logic                              R1_data,
  output logic                              G1_data,
  output logic                              B1_data,
  output logic                              R2_data,
  output logic                              G2_data,
  output logic                              B2_data,
  output logic                              A,
  output logic                              B,
  output logic                              C,
  output logic                              D,
  output logic                              E,
  output logic                              clk_out,
  output logic                              LAT,
  output logic                              OE_N,
  output logic                              frame_done
);

  localparam int unsigned RowW   = clog2(SCREEN_DEPTH);
  localparam int unsigned ColW   = clog2(SCREEN_WIDTH);
  localparam int unsigned PlaneW = (BIT_DEPTH > 1) ? clog2(BIT_DEPTH) : 1;
  localparam logic [ColW-1:0]   LastCol   = ColW'(SCREEN_WIDTH - 1);
  localparam logic [RowW-1:0]   LastRow   = RowW'(SCREEN_DEPTH - 1);
  localparam logic [PlaneW-1:0] LastPlane = PlaneW'(BIT_DEPTH - 1);

  state_e                 state_q, state_d;
  logic [ColW-1:0]        col_q, col_d;
  logic                   phase_q, phase_d;
  logic [RowW-1:0]        row_q, row_d;
  logic [PlaneW-1:0]      plane_q, plane_d;
  logic                   timer_load, timer_expire;

  logic                   rd_en_q, rd_en_d;
  logic [ColW-1:0]        rd_col_q, rd_col_d;
  logic [NumChannels-1:0] pix_q, pix_d;
  logic [NumChannels-1:0] plane_bit;
  logic [4:0]             addr_q, addr_d;
  logic                   clk_out_q, clk_out_d;
  logic                   lat_q, lat_d;
  logic                   frame_done_q, frame_done_d;

  logic [BIT_DEPTH-1:0]   chan [NumChannels];

  for (genvar g = 0; g < NumChannels; g++) begin : g_chan
    assign chan[g]      = rd_data[g*BIT_DEPTH +: BIT_DEPTH];
    assign plane_bit[g] = chan[g][plane_q];
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    phase_d      = phase_q;
    row_d        = row_q;
    plane_d      = plane_q;
    frame_done_d = 1'b0;
    timer_load   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StPrime;
          row_d   = '0;
          plane_d = '0;
        end
      end
      StPrime: begin
        state_d = StShift;
        col_d   = '0;
        phase_d = 1'b0;
      end
      StShift: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (col_q == LastCol) begin
          state_d = StLatch;
        end else begin
          col_d   = col_q + 1'b1;
          phase_d = 1'b0;
        end
      end
      StLatch: begin
        state_d    = StDisplay;
        timer_load = 1'b1;
      end
      StDisplay: begin
        if (timer_expire) begin
          state_d = StPrime;
          if (plane_q != LastPlane) begin
            plane_d = plane_q + 1'b1;
          end else begin
            plane_d = '0;
            if (row_q != LastRow) begin
              row_d = row_q + 1'b1;
            end else begin
              row_d        = '0;
              frame_done_d = 1'b1;
              if (!enable) state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin values are derived from the next state so every output comes straight from a flop.
  always_comb begin
    rd_en_d   = 1'b0;
    rd_col_d  = rd_col_q;
    pix_d     = pix_q;
    addr_d    = addr_q;
    clk_out_d = (state_d == StShift) && phase_d;
    lat_d     = (state_d == StLatch);
    if (state_d == StPrime) begin
      rd_en_d  = 1'b1;
      rd_col_d = '0;
    end else if (clk_out_d && (col_d != LastCol)) begin
      rd_en_d  = 1'b1;
      rd_col_d = col_d + 1'b1;
    end
    if ((state_q == StShift) && !phase_q) pix_d = plane_bit;
    if (lat_d && (plane_d == '0)) addr_d = 5'(row_d);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      col_q        <= '0;
      phase_q      <= 1'b0;
      row_q        <= '0;
      plane_q      <= '0;
      rd_en_q      <= 1'b0;
      rd_col_q     <= '0;
      pix_q        <= '0;
      addr_q       <= '0;
      clk_out_q    <= 1'b0;
      lat_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      phase_q      <= phase_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      rd_en_q      <= rd_en_d;
      rd_col_q     <= rd_col_d;
      pix_q        <= pix_d;
      addr_q       <= addr_d;
      clk_out_q    <= clk_out_d;
      lat_q        <= lat_d;
      frame_done_q <= frame_done_d;
    end
  end

  hub75_bcm_timer #(
    .BIT_DEPTH (BIT_DEPTH),
    .ON_BASE   (ON_BASE),
    .PlaneW    (PlaneW)
  ) u_timer (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .load_i   (timer_load),
    .plane_i  (plane_q),
    .expire_o (timer_expire),
    .oe_n_o   (OE_N)
  );

  assign rd_en           = rd_en_q;
  assign rd_row          = row_q;
  assign rd_col          = rd_col_q;
  assign R1_data         = pix_q[ChR1];
  assign G1_data         = pix_q[ChG1];
  assign B1_data         = pix_q[ChB1];
  assign R2_data         = pix_q[ChR2];
  assign G2_data         = pix_q[ChG2];
  assign B2_data         = pix_q[ChB2];
  assign {E, D, C, B, A} = addr_q;
  assign clk_out         = clk_out_q;
  assign LAT             = lat_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Bench for hub75_bcm_scanner: a panel model rebuilds each latched row and checks it.
module tb_hub75_bcm_scanner;

  localparam int unsigned W  = 4;
  localparam int unsigned SD = 2;
  localparam int unsigned SB = 2;
  localparam int unsigned SO = 4;
  localparam int unsigned LD = 16;
  localparam int unsigned LB = 3;
  localparam int unsigned LO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic en_s  = 1'b0;
  logic en_l  = 1'b0;
  logic sel   = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Small geometry instance.
  logic        s_rd_en, s_clk_out, s_lat, s_oe_n, s_fd;
  logic [0:0]  s_rd_row;
  logic [1:0]  s_rd_col;
  logic [11:0] s_rd_data = '0;
  logic [5:0]  s_pix;
  logic [4:0]  s_addr;

  // Deep instance.
  logic        l_rd_en, l_clk_out, l_lat, l_oe_n, l_fd;
  logic [3:0]  l_rd_row;
  logic [1:0]  l_rd_col;
  logic [17:0] l_rd_data = '0;
  logic [5:0]  l_pix;
  logic [4:0]  l_addr;

  hub75_bcm_scanner #(
    .SCREEN_WIDTH (W), .SCREEN_DEPTH (SD), .BIT_DEPTH (SB), .ON_BASE (SO)
  ) u_small (
    .clk_in (clk), .rst_n (rst_n), .enable (en_s),
    .rd_en (s_rd_en), .rd_row (s_rd_row), .rd_col (s_rd_col), .rd_data (s_rd_data),
    .R1_data (s_pix[5]), .G1_data (s_pix[4]), .B1_data (s_pix[3]),
    .R2_data (s_pix[2]), .G2_data (s_pix[1]), .B2_data (s_pix[0]),
    .A (s_addr[0]), .B (s_addr[1]), .C (s_addr[2]), .D (s_addr[3]), .E (s_addr[4]),
    .clk_out (s_clk_out), .LAT (s_lat), .OE_N (s_oe_n), .frame_done (s_fd)
  );

  hub75_bcm_scanner #(
    .SCREEN_WIDTH (W), .SCREEN_DEPTH (LD), .BIT_DEPTH (LB), .ON_BASE (LO)
  ) u_large (
    .clk_in (clk), .rst_n (rst_n), .enable (en_l),
    .rd_en (l_rd_en), .rd_row (l_rd_row), .rd_col (l_rd_col), .rd_data (l_rd_data),
    .R1_data (l_pix[5]), .G1_data (l_pix[4]), .B1_data (l_pix[3]),
    .R2_data (l_pix[2]), .G2_data (l_pix[1]), .B2_data (l_pix[0]),
    .A (l_addr[0]), .B (l_addr[1]), .C (l_addr[2]), .D (l_addr[3]), .E (l_addr[4]),
    .clk_out (l_clk_out), .LAT (l_lat), .OE_N (l_oe_n), .frame_done (l_fd)
  );

  // Frame buffers with one-cycle read latency.
  logic [23:0] fb_s [SD][W];
  logic [23:0] fb_l [LD][W];

  always @(posedge clk) begin
    if (s_rd_en) s_rd_data <= fb_s[s_rd_row][s_rd_col][11:0];
    if (l_rd_en) l_rd_data <= fb_l[l_rd_row][l_rd_col][17:0];
  end

  // Monitor watches whichever instance is selected.
  logic [5:0] m_pix;
  logic [4:0] m_addr;
  logic       m_clk_out, m_lat, m_oe_n, m_fd, m_rd_en;
  int         m_depth, m_bd, m_on, m_frame_len;

  always_comb begin
    m_pix       = sel ? l_pix : s_pix;
    m_addr      = sel ? l_addr : s_addr;
    m_clk_out   = sel ? l_clk_out : s_clk_out;
    m_lat       = sel ? l_lat : s_lat;
    m_oe_n      = sel ? l_oe_n : s_oe_n;
    m_fd        = sel ? l_fd : s_fd;
    m_rd_en     = sel ? l_rd_en : s_rd_en;
    m_depth     = sel ? LD : SD;
    m_bd        = sel ? LB : SB;
    m_on        = sel ? LO : SO;
    m_frame_len = m_depth * (m_bd * (2 + 2 * W) + m_on * ((1 << m_bd) - 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // What the panel should hold after shifting row/plane: bit 'plane' of each channel per column.
  function automatic logic [23:0] model_row(input int row, input int plane);
    logic [23:0] v;
    logic [23:0] px;
    v = '0;
    for (int c = 0; c < W; c++) begin
      px = sel ? fb_l[row][c] : fb_s[row][c];
      for (int ch = 0; ch < 6; ch++) v[c*6 + ch] = px[ch*m_bd + plane];
    end
    return v;
  endfunction

  logic [23:0] shift_buf;
  logic [23:0] cap [8];
  int          rises, latch_idx, latch_total, frames, oe_run, exp_on, gap, mrow, mplane;
  logic        prev_clk_out, prev_oe_n, have_prev;
  logic [4:0]  prev_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      shift_buf = '0; rises = 0; latch_idx = 0; latch_total = 0; frames = 0;
      oe_run = 0; exp_on = 0; gap = 0; have_prev = 1'b0;
      prev_clk_out = 1'b0; prev_oe_n = 1'b1; prev_addr = '0;
      for (int i = 0; i < 8; i++) cap[i] = '0;
    end else begin
      if (m_clk_out && !prev_clk_out) begin
        if (rises < W) shift_buf[rises*6 +: 6] = m_pix;
        rises++;
      end
      if (m_addr != prev_addr) chk("addr_change_gated", {m_lat, m_oe_n}, 2'b11);
      if (m_lat) begin
        mrow   = latch_idx / m_bd;
        mplane = latch_idx % m_bd;
        chk("shift_clocks", rises, W);
        chk("addr_at_latch", m_addr, mrow);
        chk("row_data", shift_buf, model_row(mrow, mplane));
        if (latch_idx < 8) cap[latch_idx] = shift_buf;
        exp_on      = m_on << mplane;
        rises       = 0;
        shift_buf   = '0;
        latch_idx   = (latch_idx + 1) % (m_depth * m_bd);
        latch_total++;
      end
      if (!m_oe_n) begin
        oe_run++;
      end else if (!prev_oe_n) begin
        chk("oe_low_cycles", oe_run, exp_on);
        oe_run = 0;
      end
      gap++;
      if (m_fd) begin
        frames++;
        chk("latches_per_frame", latch_total, frames * m_depth * m_bd);
        if (have_prev) chk("frame_period", gap, m_frame_len);
        have_prev = 1'b1;
        gap       = 0;
      end
      prev_clk_out = m_clk_out;
      prev_oe_n    = m_oe_n;
      prev_addr    = m_addr;
    end
  end

  task automatic assert_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_fd(input int n, input int budget);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (m_fd) seen++;
    end
    chk("frame_done_seen", seen, n);
  endtask

  typedef struct {
    int         ch;
    int         row;
    int         col;
    int         val;
    logic [3:0] mask;  // latch slots (row*2+plane) in which the lit bit must appear
  } vec_t;

  vec_t        vecs [5];
  logic [23:0] exp_vec;
  int          found, fds, bad;

  initial begin
    vecs[0] = '{ch: 5, row: 1, col: 2, val: 2, mask: 4'b1000};
    vecs[1] = '{ch: 4, row: 0, col: 0, val: 3, mask: 4'b0011};
    vecs[2] = '{ch: 0, row: 1, col: 3, val: 1, mask: 4'b0100};
    vecs[3] = '{ch: 2, row: 0, col: 1, val: 2, mask: 4'b0010};
    vecs[4] = '{ch: 3, row: 1, col: 0, val: 3, mask: 4'b1100};

    for (int r = 0; r < SD; r++) for (int c = 0; c < W; c++) fb_s[r][c] = '0;
    for (int r = 0; r < LD; r++) for (int c = 0; c < W; c++) fb_l[r][c] = '0;

    // Reset held with enable high: everything parked.
    sel  = 1'b0;
    en_s = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_oe_n", s_oe_n, 1'b1);
    chk("reset_lat", s_lat, 1'b0);
    chk("reset_clk_out", s_clk_out, 1'b0);
    chk("reset_addr", s_addr, 5'd0);
    chk("reset_rd", {s_rd_en, s_rd_row, s_rd_col}, 4'd0);
    chk("reset_data_fd", {s_pix, s_fd}, 7'd0);
    release_reset();
    @(negedge clk);
    chk("prime_rd_en", s_rd_en, 1'b1);
    chk("prime_rd_col", s_rd_col, 2'd0);
    chk("prime_rd_row", s_rd_row, 1'b0);
    wait_fd(3, 400);

    // Single lit pixel per vector: must show up only in its column, channel and planes.
    for (int v = 0; v < 5; v++) begin
      assert_reset();
      for (int r = 0; r < SD; r++) for (int c = 0; c < W; c++) fb_s[r][c] = '0;
      fb_s[vecs[v].row][vecs[v].col][vecs[v].ch*SB +: SB] = 2'(vecs[v].val);
      release_reset();
      wait_fd(1, 200);
      for (int i = 0; i < 4; i++) begin
        exp_vec = vecs[v].mask[i] ? (24'd1 << (vecs[v].col * 6 + vecs[v].ch)) : 24'd0;
        chk("table_latch", cap[i], exp_vec);
      end
    end

    // Asynchronous reset in the middle of a row-1 display period.
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge clk);
      if (s_addr == 5'd1 && !s_oe_n) found = 1;
    end
    chk("reach_display_row1", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_oe_n", s_oe_n, 1'b1);
    chk("async_addr", s_addr, 5'd0);
    chk("async_rd", {s_rd_en, s_rd_row, s_rd_col}, 4'd0);
    chk("async_lat_clk", {s_lat, s_clk_out}, 2'd0);
    repeat (2) @(negedge clk);
    release_reset();
    found = 0;
    for (int i = 0; i < 5 && found == 0; i++) begin
      @(negedge clk);
      if (s_rd_en) found = 1;
    end
    chk("post_reset_rd_seen", found, 1);
    chk("post_reset_rd_addr", {s_rd_row, s_rd_col}, 3'd0);

    // Deep panel with random content over three frames.
    assert_reset();
    sel  = 1'b1;
    en_s = 1'b0;
    en_l = 1'b1;
    for (int r = 0; r < LD; r++) for (int c = 0; c < W; c++) fb_l[r][c] = 24'($urandom);
    release_reset();
    wait_fd(3, 3000);

    // Drop enable while row 5 is lit: frame must finish, then go quiet.
    found = 0;
    for (int i = 0; i < 800 && found == 0; i++) begin
      @(negedge clk);
      if (m_addr == 5'd5 && !m_oe_n) found = 1;
    end
    chk("reach_row5", found, 1);
    en_l = 1'b0;
    fds  = 0;
    bad  = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (m_fd) fds++;
      if (fds > 0 && (m_rd_en || !m_oe_n || m_clk_out || m_lat)) bad++;
    end
    chk("frames_after_drop", fds, 1);
    chk("idle_quiet_cycles", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
